// File: rtl/noc_fifo_pkg.sv
// Shared types and pointer-coding helpers for the NoC write-side FIFO logic.
// Gray/binary conversions work on a fixed wide vector; callers cast to their pointer width.
package noc_fifo_pkg;

    localparam int FN_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] gray);
        logic [FN_W-1:0] bin;
        bin[FN_W-1] = gray[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_ptr_reg.sv
// Write pointer register pair: binary count and its gray image, both registered.
// The gray register is loaded from the next binary value so the two never disagree.
module gray_ptr_reg
    import noc_fifo_pkg::*;
#(
    parameter int PTR_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_inc,
    output logic [PTR_WIDTH-2:0] o_addr,
    output logic [PTR_WIDTH-1:0] o_gray
);

    logic [PTR_WIDTH-1:0] bin_reg;
    logic [PTR_WIDTH-1:0] bin_next;
    logic [PTR_WIDTH-1:0] gray_reg;
    logic [PTR_WIDTH-1:0] gray_next;

    always_comb begin
        bin_next  = i_inc ? bin_reg + PTR_WIDTH'(1) : bin_reg;
        gray_next = PTR_WIDTH'(bin2gray(FN_W'(bin_next)));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bin_reg  <= '0;
            gray_reg <= '0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
        end
    end

    assign o_addr = bin_reg[PTR_WIDTH-2:0];
    assign o_gray = gray_reg;

endmodule

// File: rtl/gray_fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter feeding the write side of a gray-pointer async FIFO.
// An owner keeps the grant until its last flit is written; full and owner stalls simply hold.
module gray_fifo_wr_arbiter
    import noc_fifo_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ-1:0]            i_last,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
    input  logic [PTR_WIDTH-1:0]        i_rd_ptr_gray,
    output logic [N_REQ-1:0]            o_gnt,
    output logic                        o_wr_en,
    output logic [PTR_WIDTH-2:0]        o_wr_addr,
    output logic [DATA_WIDTH-1:0]       o_wr_data,
    output logic [PTR_WIDTH-1:0]        o_wr_ptr_gray,
    output logic                        o_full
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Full when the write pointer is exactly one lap ahead: two gray MSBs differ.
    localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(3) << (PTR_WIDTH - 2);

    state_e                state_reg, state_next;
    logic [IDX_W-1:0]      owner_reg, owner_next;
    logic [IDX_W-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [N_REQ-1:0]      gnt_reg, gnt_next;
    logic [IDX_W-1:0]      pick;
    logic [N_REQ-1:0]      pick_onehot;
    logic                  xfer;
    logic [PTR_WIDTH-1:0]  wr_gray;
    logic [DATA_WIDTH-1:0] data_slice [N_REQ];

    function automatic logic [IDX_W-1:0] rr_select(input logic [N_REQ-1:0] req,
                                                   input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(start) + i) % N_REQ;
            if (!found && req[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign data_slice[gi]  = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign pick_onehot[gi] = (pick == IDX_W'(gi));
        end
    endgenerate

    assign pick   = rr_select(i_req, rr_ptr_reg);
    assign o_full = (wr_gray == (i_rd_ptr_gray ^ FULL_MASK));
    assign xfer   = !i_rst && (state_reg == BUSY) && i_req[owner_reg] && !o_full;

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        gnt_next    = gnt_reg;
        case (state_reg)
            IDLE: begin
                if (|i_req) begin
                    state_next = BUSY;
                    owner_next = pick;
                    gnt_next   = pick_onehot;
                end
            end
            BUSY: begin
                if (xfer && i_last[owner_reg]) begin
                    state_next  = IDLE;
                    gnt_next    = '0;
                    rr_ptr_next = (owner_reg == IDX_W'(N_REQ - 1)) ? '0 : owner_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
            gnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            gnt_reg    <= gnt_next;
        end
    end

    gray_ptr_reg #(
        .PTR_WIDTH(PTR_WIDTH)
    ) u_wr_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (xfer),
        .o_addr(o_wr_addr),
        .o_gray(wr_gray)
    );

    assign o_gnt         = gnt_reg;
    assign o_wr_en       = xfer;
    assign o_wr_data     = data_slice[owner_reg];
    assign o_wr_ptr_gray = wr_gray;

endmodule

// File: tb/tb_gray_fifo_wr_arbiter.sv
// Bench for gray_fifo_wr_arbiter: vector table, directed corner sequences and random traffic
// against a packet/occupancy-level reference model.
module tb_gray_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int PW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*DW-1:0] data;
    logic [PW-1:0]   rd_gray;
    logic [N-1:0]    gnt;
    logic            wr_en;
    logic [PW-2:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [PW-1:0]   wr_gray;
    logic            full;

    gray_fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_last       (last),
        .i_data       (data),
        .i_rd_ptr_gray(rd_gray),
        .o_gnt        (gnt),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_wr_ptr_gray(wr_gray),
        .o_full       (full)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: who owns the FIFO, whose turn is next, how many flits written/read.
    int m_owner;   // -1 when no packet is in progress
    int m_rr;
    int m_wr;      // write count mod 16
    int rd_cnt;    // read count mod 16, driven onto rd_gray
    bit m_exp_wr;

    logic [N-1:0]  s_gnt;
    logic          s_wr;
    logic [PW-2:0] s_addr;
    logic [PW-1:0] s_gray;
    logic          s_full;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] last;
        logic [N-1:0] gnt;
        logic         wr;
        logic [PW-1:0] gray;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [PW-1:0] gray_of(input int v);
        logic [PW-1:0] b;
        b = PW'(v & 15);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive_rd();
        rd_gray = gray_of(rd_cnt);
    endtask

    // One clock: sample/check at the falling edge, advance the model at the rising edge.
    task automatic tick(input bit en);
        logic          e_full;
        logic [N-1:0]  e_gnt;
        @(negedge clk);
        s_gnt  = gnt;
        s_wr   = wr_en;
        s_addr = wr_addr;
        s_gray = wr_gray;
        s_full = full;
        e_full   = (((m_wr - rd_cnt) & 15) == 8);
        e_gnt    = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        m_exp_wr = !rst && (m_owner >= 0) && req[m_owner] && !e_full;
        if (en) begin
            chk("m_gnt", 64'(gnt), 64'(e_gnt));
            chk("m_wr_en", 64'(wr_en), 64'(m_exp_wr));
            chk("m_full", 64'(full), 64'(e_full));
            chk("m_gray", 64'(wr_gray), 64'(gray_of(m_wr)));
            if (m_exp_wr) begin
                chk("m_addr", 64'(wr_addr), 64'(m_wr % 8));
                chk("m_data", 64'(wr_data), 64'(data[m_owner*DW +: DW]));
            end
        end
        @(posedge clk);
        if (rst) begin
            m_owner = -1;
            m_rr    = 0;
            m_wr    = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner < 0 && req[(m_rr + i) % N]) m_owner = (m_rr + i) % N;
            end
        end else if (m_exp_wr) begin
            m_wr = (m_wr + 1) & 15;
            if (last[m_owner]) begin
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; req = '0; last = '0; rd_cnt = 0;
        drive_rd();
        tick(1);
        rst = 1'b0;
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) data[k*DW +: DW] = $urandom;
    endtask

    // Run until `target` writes have been observed, bounded by a cycle budget.
    task automatic run_writes(input int target, input string name);
        int writes = 0;
        int budget = 0;
        while (writes < target && budget < 60) begin
            rand_data();
            tick(1);
            if (s_wr) writes++;
            budget++;
        end
        if (writes < target) chk({name, "_timeout"}, 64'(writes), 64'(target));
    endtask

    function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                                input logic [3:0] g, input logic w, input logic [3:0] gr);
        vec_t v;
        v.rst = r; v.req = rq; v.last = ls; v.gnt = g; v.wr = w; v.gray = gr;
        tbl.push_back(v);
    endfunction

    initial begin
        int   steps;
        int   bad_steps;
        int   waddr[$];
        logic [PW-1:0] prev_gray;

        m_owner = -1; m_rr = 0; m_wr = 0; rd_cnt = 0;
        rst = 1'b1; req = '0; last = '0; data = '0;
        drive_rd();
        tick(0);
        tick(0);
        rst = 1'b0;

        // Alternating single-flit packets from 0 and 2, then a 3-flit packet from 1 with 3 waiting.
        add(0, 4'b0101, 4'b0101, 4'b0000, 0, 4'b0000);
        add(0, 4'b0101, 4'b0101, 4'b0001, 1, 4'b0000);
        add(0, 4'b0101, 4'b0101, 4'b0000, 0, 4'b0001);
        add(0, 4'b0101, 4'b0101, 4'b0100, 1, 4'b0001);
        add(0, 4'b0101, 4'b0101, 4'b0000, 0, 4'b0011);
        add(0, 4'b0101, 4'b0101, 4'b0001, 1, 4'b0011);
        add(0, 4'b0101, 4'b0101, 4'b0000, 0, 4'b0010);
        add(0, 4'b0101, 4'b0101, 4'b0100, 1, 4'b0010);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0110);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0110);
        add(0, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000);
        add(0, 4'b1010, 4'b0000, 4'b0010, 1, 4'b0000);
        add(0, 4'b1010, 4'b0000, 4'b0010, 1, 4'b0001);
        add(0, 4'b1010, 4'b0010, 4'b0010, 1, 4'b0011);
        add(0, 4'b1000, 4'b0000, 4'b0000, 0, 4'b0010);
        add(0, 4'b1000, 4'b1000, 4'b1000, 1, 4'b0010);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0110);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; last = tbl[i].last;
            rand_data();
            tick(1);
            chk($sformatf("tbl%0d_gnt", i), 64'(s_gnt), 64'(tbl[i].gnt));
            chk($sformatf("tbl%0d_wr", i), 64'(s_wr), 64'(tbl[i].wr));
            chk($sformatf("tbl%0d_gray", i), 64'(s_gray), 64'(tbl[i].gray));
            chk($sformatf("tbl%0d_full", i), 64'(s_full), 64'(0));
        end
        rst = 1'b0;

        // Fill to full with the read pointer parked at zero, then release one slot.
        reset_dut();
        req = 4'b0100; last = '0;
        run_writes(8, "fill");
        tick(1);
        chk("full_gray", 64'(s_gray), 64'(4'b1100));
        chk("full_flag", 64'(s_full), 64'(1));
        chk("full_no_wr0", 64'(s_wr), 64'(0));
        tick(1);
        chk("full_no_wr1", 64'(s_wr), 64'(0));
        rd_cnt = 1; drive_rd();
        tick(1);
        chk("unfull_wr", 64'(s_wr), 64'(1));
        chk("unfull_flag", 64'(s_full), 64'(0));

        // Sixteen writes with the reader keeping up: pointer wraps, one gray bit per step.
        reset_dut();
        req = 4'b0001; last = '0;
        steps = 0; bad_steps = 0; prev_gray = '0;
        for (int c = 0; c < 60 && waddr.size() < 16; c++) begin
            rd_cnt = m_wr; drive_rd();
            rand_data();
            tick(1);
            if (s_wr) waddr.push_back(int'(s_addr));
            if (s_gray != prev_gray) begin
                if ($countones(s_gray ^ prev_gray) == 1) steps++;
                else bad_steps++;
            end
            prev_gray = s_gray;
        end
        rd_cnt = m_wr; drive_rd();
        tick(1);
        if (s_gray != prev_gray) begin
            if ($countones(s_gray ^ prev_gray) == 1) steps++;
            else bad_steps++;
        end
        chk("wrap_writes", 64'(waddr.size()), 64'(16));
        if (waddr.size() == 16) begin
            chk("wrap_addr7", 64'(waddr[7]), 64'(7));
            chk("wrap_addr8", 64'(waddr[8]), 64'(0));
        end
        chk("wrap_gray_zero", 64'(s_gray), 64'(0));
        chk("wrap_steps", 64'(steps), 64'(16));
        chk("wrap_bad_steps", 64'(bad_steps), 64'(0));

        // Owner stalls mid-packet while another requester waits.
        reset_dut();
        req = 4'b1010; last = '0;
        run_writes(2, "stall");
        req = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            tick(1);
            chk($sformatf("stall%0d_wr", c), 64'(s_wr), 64'(0));
            chk($sformatf("stall%0d_gnt", c), 64'(s_gnt), 64'(4'b0010));
        end
        req = 4'b1010;
        tick(1);
        chk("resume_wr", 64'(s_wr), 64'(1));
        chk("resume_gnt", 64'(s_gnt), 64'(4'b0010));

        // Reset in the middle of a packet.
        reset_dut();
        req = 4'b0001; last = '0;
        run_writes(3, "midrst");
        rst = 1'b1;
        tick(1);
        chk("midrst_wr", 64'(s_wr), 64'(0));
        rst = 1'b0; req = '0;
        tick(1);
        chk("midrst_gnt", 64'(s_gnt), 64'(0));
        chk("midrst_gray", 64'(s_gray), 64'(0));
        chk("midrst_full", 64'(s_full), 64'(0));

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (rst) rd_cnt = 0;
            else if (((m_wr - rd_cnt) & 15) != 0 && $urandom_range(0, 1) == 1) rd_cnt = (rd_cnt + 1) & 15;
            drive_rd();
            req  = N'($urandom);
            last = N'($urandom) & N'($urandom);
            rand_data();
            tick(1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/gray_fifo_wr_arbiter.md
GRAY_FIFO_WR_ARBITER -- requirements
Module: gray_fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, at least 2.
REQ-002 Parameter DATA_WIDTH, default 32: flit width.
REQ-003 Parameter PTR_WIDTH, default 4: gray pointer width; FIFO depth = 2^(PTR_WIDTH-1).
REQ-004 Port i_clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port i_rst, input, 1: synchronous, active-high reset.
REQ-006 Port i_req, input, N_REQ: per-requester flit valid.
REQ-007 Port i_last, input, N_REQ: per-requester last-flit-of-packet marker, qualified by i_req.
REQ-008 Port i_data, input, N_REQ*DATA_WIDTH: requester k's flit in slice [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port i_rd_ptr_gray, input, PTR_WIDTH: read pointer, gray-coded, already synchronized into i_clk.
REQ-010 Port o_gnt, output, N_REQ: one-hot or zero; acts as ready to the owning requester.
REQ-011 Port o_wr_en, output, 1: FIFO RAM write strobe.
REQ-012 Port o_wr_addr, output, PTR_WIDTH-1: RAM write address (binary write pointer without MSB).
REQ-013 Port o_wr_data, output, DATA_WIDTH: the owner's i_data slice.
REQ-014 Port o_wr_ptr_gray, output, PTR_WIDTH: registered gray write pointer toward the read domain.
REQ-015 Port o_full, output, 1: FIFO full.

Function
REQ-016 The FSM SHALL have two states: IDLE and BUSY (packet locked to one owner).
REQ-017 In IDLE with any i_req set, it SHALL select the first requester at or after rr_ptr (wrapping at N_REQ), store it as owner, and enter BUSY on the next edge.
REQ-018 In IDLE, o_gnt SHALL be 0 and no write SHALL occur.
REQ-019 In BUSY, o_gnt SHALL be registered one-hot of owner, regardless of i_req.
REQ-020 Transfer condition SHALL be BUSY && i_req[owner] && !o_full; o_wr_en SHALL equal it combinationally, with o_wr_data and o_wr_addr valid in the same cycle.
REQ-021 On each transfer, the binary and gray write pointers SHALL advance by one at the next edge, wrapping modulo 2^PTR_WIDTH.
REQ-022 o_wr_ptr_gray SHALL always equal bin ^ (bin >> 1) of the registered binary pointer.
REQ-023 o_full SHALL be 1 when o_wr_ptr_gray equals i_rd_ptr_gray with its two MSBs inverted; it is combinational from registered pointer and input.
REQ-024 A transfer with i_last[owner]=1 SHALL return the FSM to IDLE and set rr_ptr = (owner+1) mod N_REQ at the next edge.
REQ-025 In BUSY, deasserting i_req[owner] or o_full=1 SHALL hold BUSY with no write; other requesters SHALL never preempt the owner.
REQ-026 i_last without a transfer SHALL be ignored.
REQ-027 Minimum packet turnaround SHALL be one IDLE cycle between packets.

Reset
REQ-028 With i_rst=1 at an edge: state IDLE, owner 0, rr_ptr 0, pointers 0, o_gnt 0; o_wr_en SHALL be 0 while i_rst=1.
REQ-029 Reset mid-packet SHALL abandon the packet and clear pointers; no partial state survives.

Structure
REQ-030 Package noc_fifo_pkg SHALL hold the state enum (IDLE, BUSY) and bin-to-gray/gray-to-bin functions.
REQ-031 One sub-module, gray_ptr_reg, SHALL hold the binary and gray pointer registers, with inputs i_clk, i_rst, i_inc.
REQ-032 Round-robin selection SHALL be a combinational function inside gray_fifo_wr_arbiter, not a separate module.

Verification
REQ-033 Reset, then i_req=4'b0101, single-flit packets -> grants 0,2,0,2 in order; o_wr_ptr_gray 0000,0001,0011,0010,0110.
REQ-034 Requester 1 sends a 3-flit packet while requester 3 requests -> o_gnt stays 0010 for 3 transfers; one IDLE cycle; then 1000.
REQ-035 Hold i_rd_ptr_gray=0000 and write 8 flits -> o_wr_ptr_gray=1100, o_full=1; a ninth i_req produces no o_wr_en until i_rd_ptr_gray=0001.
REQ-036 Write 16 flits with the read pointer tracking -> binary pointer wraps 1111 to 0000; o_wr_addr wraps 7 to 0; gray changes one bit per step.
REQ-037 Owner drops i_req for 2 cycles mid-packet -> no writes, o_gnt unchanged, resumes on reassertion.
REQ-038 Assert i_rst in BUSY after 3 writes -> next cycle IDLE, o_gnt=0, o_wr_ptr_gray=0000, o_full=0.
